// File: rtl/mem_pkg.sv
// Shared types for the store buffer: default widths, FSM state and the buffered entry layout.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 10;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic                      valid;
        logic [DEFAULT_ADDR_W-1:0] addr;
        logic [DEFAULT_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Combinational store-to-load forwarding: scans entries from youngest to oldest and returns the first address match.
module sb_fwd_match
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  sb_entry_t [DEPTH-1:0]              entries_i,
    input  logic      [$clog2(DEPTH)-1:0]      wr_ptr_i,
    input  logic      [DEFAULT_ADDR_W-1:0]     ld_addr_i,
    output logic                               hit_o,
    output logic      [DEFAULT_DATA_W-1:0]     data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]          idx;
    logic                      found;
    logic [DEFAULT_DATA_W-1:0] foundData;

    // The slot just behind wr_ptr holds the youngest store, so walk backwards from there.
    always_comb begin
        idx       = '0;
        found     = 1'b0;
        foundData = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            idx = wr_ptr_i - PTR_W'(i);
            if (!found && entries_i[idx].valid && (entries_i[idx].addr == ld_addr_i)) begin
                found     = 1'b1;
                foundData = entries_i[idx].data;
            end
        end
    end

    assign hit_o  = found;
    assign data_o = foundData;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a single-port data memory: queues stores,
// drains them when the port is free, forwards to matching loads, and forces a drain under starvation.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [DATA_W-1:0]        st_data,
    output logic                     st_ready,
    input  logic                     ld_req,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_hit,
    output logic [DATA_W-1:0]        ld_fwd_data,
    output logic                     ld_stall,
    output logic                     mem_wen,
    output logic                     mem_readEn,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [DATA_W-1:0]        mem_dataIn,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    sb_entry_t [DEPTH-1:0] entries_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [STV_W-1:0]      starve_q;
    logic [STV_W-1:0]      starve_d;
    sb_state_t             state_q;
    sb_state_t             state_d;

    sb_entry_t head;
    logic      notEmpty;
    logic      enq;
    logic      drain;

    assign head     = entries_q[rd_ptr_q];
    assign notEmpty = (count_q != '0);
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign enq      = st_valid && st_ready;
    // Drain is gated by rst so a reset cycle never commits a pending store to memory.
    assign drain    = !rst && notEmpty && ((state_q == FORCE) || !ld_req);

    assign mem_wen     = drain;
    assign mem_readEn  = (state_q == NORMAL) && ld_req;
    assign mem_address = mem_readEn ? ld_addr : head.addr;
    assign mem_dataIn  = head.data;
    assign ld_stall    = (state_q == FORCE) && ld_req;
    assign empty       = !notEmpty;
    assign count       = count_q;

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries_i (entries_q),
        .wr_ptr_i  (wr_ptr_q),
        .ld_addr_i (ld_addr),
        .hit_o     (ld_hit),
        .data_o    (ld_fwd_data)
    );

    always_comb begin
        count_d = count_q;
        if (enq && !drain) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && drain) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Starvation counts only cycles where a load holds the port while stores wait.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (state_q == FORCE) begin
            state_d  = NORMAL;
            starve_d = '0;
        end else if (drain) begin
            starve_d = '0;
        end else if (ld_req && notEmpty) begin
            starve_d = starve_q + STV_W'(1);
            if (starve_d >= STV_W'(STARVE_LIMIT)) begin
                state_d = FORCE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            state_q  <= NORMAL;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            if (drain) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q                  <= rd_ptr_q + PTR_W'(1);
            end
            if (enq) begin
                entries_q[wr_ptr_q] <= '{valid: 1'b1, addr: st_addr, data: st_data};
                wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Randomised plus directed bench for store_buffer: a queue-level reference model predicts each cycle,
// and a monitor compares port outputs and memory writes against scoreboard queues.
module tb_store_buffer;

    localparam int DEPTH        = 4;
    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 8;

    logic              clk;
    logic              rst;
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_fwd_data;
    logic              ld_stall;
    logic              mem_wen;
    logic              mem_readEn;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_dataIn;
    logic              empty;
    logic [2:0]        count;

    store_buffer #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_hit      (ld_hit),
        .ld_fwd_data (ld_fwd_data),
        .ld_stall    (ld_stall),
        .mem_wen     (mem_wen),
        .mem_readEn  (mem_readEn),
        .mem_address (mem_address),
        .mem_dataIn  (mem_dataIn),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } store_t;

    typedef struct {
        bit                rstCyc;
        bit                wen;
        bit                ren;
        bit                stall;
        bit                hit;
        logic [DATA_W-1:0] fwd;
        logic [ADDR_W-1:0] raddr;
        int                cnt;
        bit                rdy;
    } exp_t;

    store_t pend[$];
    store_t writeQ[$];
    exp_t   cycQ[$];
    int     starve;
    bit     forceCyc;
    int     nChecks;
    int     nFails;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: pending stores as a FIFO queue, forwarding as a youngest-first search.
    task automatic applyStimulus(input bit r, input bit sv, input logic [ADDR_W-1:0] sa,
                                 input logic [DATA_W-1:0] sd, input bit lr, input logic [ADDR_W-1:0] la);
        exp_t e;
        bit   drn;
        int   n;
        @(posedge clk);
        #1;
        rst      = r;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        ld_req   = lr;
        ld_addr  = la;
        e        = '{default: 0};
        if (r) begin
            e.rstCyc = 1'b1;
            cycQ.push_back(e);
            pend.delete();
            starve   = 0;
            forceCyc = 1'b0;
            return;
        end
        n       = pend.size();
        drn     = (n > 0) && (forceCyc || !lr);
        e.wen   = drn;
        e.ren   = !forceCyc && lr;
        e.stall = forceCyc && lr;
        e.raddr = la;
        e.cnt   = n;
        e.rdy   = (n < DEPTH);
        e.hit   = 1'b0;
        e.fwd   = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!e.hit && pend[i].addr == la) begin
                e.hit = 1'b1;
                e.fwd = pend[i].data;
            end
        end
        cycQ.push_back(e);
        if (drn) writeQ.push_back(pend.pop_front());
        if (sv && n < DEPTH) pend.push_back('{addr: sa, data: sd});
        if (forceCyc) begin
            forceCyc = 1'b0;
            starve   = 0;
        end else if (drn) begin
            starve = 0;
        end else if (lr && n > 0) begin
            starve++;
            if (starve == STARVE_LIMIT) forceCyc = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        exp_t   e;
        store_t w;
        if (cycQ.size() != 0) begin
            e = cycQ.pop_front();
            if (e.rstCyc) begin
                checkOutput("mem_wen_in_reset", 64'(mem_wen), 64'(0));
            end else begin
                checkOutput("mem_wen", 64'(mem_wen), 64'(e.wen));
                checkOutput("mem_readEn", 64'(mem_readEn), 64'(e.ren));
                checkOutput("ld_stall", 64'(ld_stall), 64'(e.stall));
                checkOutput("ld_hit", 64'(ld_hit), 64'(e.hit));
                checkOutput("ld_fwd_data", 64'(ld_fwd_data), 64'(e.fwd));
                checkOutput("count", 64'(count), 64'(e.cnt));
                checkOutput("empty", 64'(empty), 64'(e.cnt == 0));
                checkOutput("st_ready", 64'(st_ready), 64'(e.rdy));
                if (e.ren) checkOutput("load_address", 64'(mem_address), 64'(e.raddr));
            end
        end
        if (mem_wen) begin
            if (writeQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h expected no write", mem_address, mem_dataIn);
            end else begin
                w = writeQ.pop_front();
                checkOutput("write_addr", 64'(mem_address), 64'(w.addr));
                checkOutput("write_data", 64'(mem_dataIn), 64'(w.data));
            end
        end
    end

    initial begin
        logic [ADDR_W-1:0] a;
        int                guard;
        nChecks  = 0;
        nFails   = 0;
        starve   = 0;
        forceCyc = 1'b0;
        rst      = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        ld_req   = 1'b0;
        ld_addr  = '0;

        // Reset held two cycles, then one idle cycle checks reset values.
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Single store followed by idle drain.
        applyStimulus(0, 1, 10'h010, 32'hDEADBEEF, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Fill while loads hold the port, try a fifth store, then drain.
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 10'h100 + 10'(i), 32'hA000 + 32'(i), 1, 10'h3FF);
        applyStimulus(0, 1, 10'h1FF, 32'hBAD, 1, 10'h3FF);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Youngest-match forwarding and a miss.
        applyStimulus(0, 1, 10'h020, 32'h1111, 1, 10'h020);
        applyStimulus(0, 1, 10'h020, 32'h2222, 1, 10'h020);
        applyStimulus(0, 0, 0, 0, 1, 10'h020);
        applyStimulus(0, 0, 0, 0, 1, 10'h021);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Starvation: one store pending under continuous loads.
        applyStimulus(0, 1, 10'h030, 32'hCAFE, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 1, 10'h030);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Reset with three stores pending discards them.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 10'h050 + 10'(i), 32'h5000 + 32'(i), 1, 10'h3FF);
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0);

        // Random traffic over a small address window to exercise hits and starvation.
        for (int i = 0; i < 400; i++) begin
            a = 10'h040 + 10'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                          10'h040 + 10'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 7), a);
        end

        guard = 0;
        while (pend.size() != 0 && guard < 50) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            guard++;
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("writes_drained", 64'(writeQ.size()), 64'(0));
        checkOutput("final_empty", 64'(empty), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
